// File: rtl/quadrature_gen_mmio.sv
// Bus-programmable quadrature generator: emits a burst of Gray-coded edges on enc_a/enc_b
// with a programmable period, direction and edge count, tracking the net signed position.
module quadrature_gen_mmio #(
  parameter int          PERIOD_W       = 16,
  parameter int unsigned DEFAULT_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        enc_a,
  output logic        enc_b
);

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_PERIOD = 5'h04;
  localparam logic [4:0] ADDR_STEPS  = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;
  localparam logic [4:0] ADDR_POS    = 5'h10;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic                  enable_q, enable_d;
  logic                  dir_q, dir_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [31:0]           remaining_q, remaining_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           pos_q, pos_d;
  logic                  enc_a_q, enc_a_d;
  logic                  enc_b_q, enc_b_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [4:0]            addr;
  logic                  wr_ctrl, wr_period, wr_steps;
  logic                  clr_pos, stop_req, start, err_set, fire, last_edge;
  logic [PERIOD_W-1:0]   period_eff;
  logic                  unused_addr_bits;

  assign addr             = bus_addr[4:0];
  assign unused_addr_bits = ^bus_addr[31:5];

  assign wr_ctrl    = bus_we && (addr == ADDR_CTRL);
  assign wr_period  = bus_we && (addr == ADDR_PERIOD);
  assign wr_steps   = bus_we && (addr == ADDR_STEPS);
  assign clr_pos    = wr_ctrl && bus_wdata[2];
  assign stop_req   = (state_q == ST_RUN) && wr_ctrl && (bus_wdata[3] || !bus_wdata[0]);
  assign start      = wr_steps && (bus_wdata != 32'd0) && enable_q && (state_q == ST_IDLE);
  assign err_set    = wr_steps && (bus_wdata != 32'd0) && (!enable_q || (state_q == ST_RUN));
  assign period_eff = (period_q == '0) ? PERIOD_W'(1) : period_q;
  // >= rather than == so a PERIOD shrunk mid-run below the live count fires at once
  assign fire       = (state_q == ST_RUN) && !stop_req && (cnt_q >= period_eff - PERIOD_W'(1));
  assign last_edge  = fire && (remaining_q == 32'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (stop_req || last_edge) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    enable_d    = enable_q;
    dir_d       = dir_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    done_d      = done_q;
    err_d       = err_q;
    pos_d       = pos_q;
    enc_a_d     = enc_a_q;
    enc_b_d     = enc_b_q;
    rdata_d     = rdata_q;

    if (wr_ctrl) begin
      enable_d = bus_wdata[0];
      dir_d    = bus_wdata[1];
    end
    if (wr_period) period_d = bus_wdata[PERIOD_W-1:0];
    if (err_set) err_d = 1'b1;

    if (start) begin
      remaining_d = bus_wdata;
      cnt_d       = '0;
      done_d      = 1'b0;
    end else if (stop_req) begin
      remaining_d = 32'd0;
    end else if (fire) begin
      cnt_d       = '0;
      remaining_d = remaining_q - 32'd1;
      if (last_edge) done_d = 1'b1;
      // fwd: equal levels toggle B, unequal toggle A; rev is the mirror
      if ((enc_a_q == enc_b_q) == dir_q) enc_b_d = !enc_b_q;
      else                               enc_a_d = !enc_a_q;
      pos_d = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end

    if (clr_pos) pos_d = 32'd0;

    if (bus_re) begin
      case (addr)
        ADDR_CTRL:   rdata_d = {30'd0, dir_q, enable_q};
        ADDR_PERIOD: rdata_d = 32'(period_q);
        ADDR_STEPS:  rdata_d = remaining_q;
        ADDR_STATUS: rdata_d = {28'd0, dir_q, err_q, done_q, (state_q == ST_RUN)};
        ADDR_POS:    rdata_d = pos_q;
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      dir_q       <= 1'b0;
      period_q    <= PERIOD_W'(DEFAULT_PERIOD);
      cnt_q       <= '0;
      remaining_q <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pos_q       <= 32'd0;
      enc_a_q     <= 1'b0;
      enc_b_q     <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      dir_q       <= dir_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pos_q       <= pos_d;
      enc_a_q     <= enc_a_d;
      enc_b_q     <= enc_b_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign enc_a     = enc_a_q;
  assign enc_b     = enc_b_q;

endmodule

// File: tb/tb_quadrature_gen_mmio.sv
// Bench for quadrature_gen_mmio: register vectors, hand-written bursts and random bursts
// against a phase/position model counted in whole edges.
module tb_quadrature_gen_mmio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        enc_a, enc_b;

  quadrature_gen_mmio dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .enc_a(enc_a), .enc_b(enc_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int m_pidx = 0;   // phase index, 0..3 along the forward sequence
  int m_pos  = 0;   // net edges emitted
  bit m_err  = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  function automatic logic [1:0] gray(int i);
    case (i & 3)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(logic [31:0] a, output logic [31:0] d);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pidx = 0; m_pos = 0; m_err = 0;
  endtask

  // Run one complete burst and check outputs every cycle against elapsed-time edge count.
  task automatic burst(bit dir, int per, int steps);
    int p_eff, sgn, p0, edges;
    logic [31:0] d;
    p_eff = (per == 0) ? 1 : per;
    sgn   = dir ? 1 : -1;
    p0    = m_pidx;
    bus_write(32'h0, {30'd0, dir, 1'b1});
    bus_write(32'h4, per);
    bus_write(32'h8, steps);
    for (int j = 0; j <= steps * p_eff + 2; j++) begin
      edges = j / p_eff;
      if (edges > steps) edges = steps;
      check("phase", {30'd0, enc_a, enc_b}, {30'd0, gray(p0 + sgn * edges)});
      if (j == 1 && steps * p_eff >= 3) begin
        bus_addr = 32'hC; bus_re = 1'b1;
      end
      if (j == 2 && steps * p_eff >= 3) begin
        bus_re = 1'b0;
        check("status_run", bus_rdata, {28'd0, dir, m_err, 1'b0, 1'b1});
      end
      @(negedge clk);
    end
    m_pidx = (p0 + sgn * steps) & 3;
    m_pos  = m_pos + sgn * steps;
    bus_read(32'hC, d);
    check("status_done", d, {28'd0, dir, m_err, 1'b1, 1'b0});
    bus_read(32'h10, d);
    check("position", d, 32'(m_pos));
    bus_read(32'h8, d);
    check("steps_left", d, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] d;
    logic [1:0]  frozen;

    vecs.push_back('{1, 32'h0C, 32'h0});
    vecs.push_back('{1, 32'h10, 32'h0});
    vecs.push_back('{1, 32'h04, 32'h4});
    vecs.push_back('{1, 32'h00, 32'h0});
    vecs.push_back('{1, 32'h08, 32'h0});
    vecs.push_back('{0, 32'h04, 32'hABCD1234});
    vecs.push_back('{1, 32'h04, 32'h1234});
    vecs.push_back('{0, 32'h00, 32'hF});
    vecs.push_back('{1, 32'h00, 32'h3});
    vecs.push_back('{1, 32'h0C, 32'h8});
    vecs.push_back('{0, 32'h14, 32'hFFFFFFFF});
    vecs.push_back('{1, 32'h14, 32'h0});
    vecs.push_back('{1, 32'h1C, 32'h0});
    vecs.push_back('{0, 32'h08, 32'h0});
    vecs.push_back('{1, 32'h0C, 32'h8});
    vecs.push_back('{0, 32'h00, 32'h0});
    vecs.push_back('{0, 32'h08, 32'h5});
    vecs.push_back('{1, 32'h0C, 32'h4});
    vecs.push_back('{1, 32'h08, 32'h0});

    do_reset();
    check("reset_ab", {30'd0, enc_a, enc_b}, 32'd0);
    check("reset_rdata", bus_rdata, 32'd0);
    foreach (vecs[i]) begin
      if (vecs[i].is_rd) begin
        bus_read(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].data);
      end else begin
        bus_write(vecs[i].addr, vecs[i].data);
      end
    end

    do_reset();
    burst(1'b1, 2, 20);
    burst(1'b0, 2, 8);

    // Simultaneous read and write returns the old value
    bus_addr = 32'h4; bus_wdata = 32'd9; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    check("rw_same_cycle", bus_rdata, 32'd2);
    bus_read(32'h4, d);
    check("rw_after", d, 32'd9);

    // STEPS write while busy, then disable mid-run (edges at +5,+10; disable lands at +8)
    begin
      int p0;
      p0 = m_pidx;
      bus_write(32'h0, 32'h3);
      bus_write(32'h4, 32'd5);
      bus_write(32'h8, 32'd10);
      repeat (5) @(negedge clk);
      bus_write(32'h8, 32'd5);
      m_err = 1;
      bus_read(32'hC, d);
      check("busy_err", d, 32'hD);
      bus_write(32'h0, 32'h0);
      bus_read(32'hC, d);
      check("abort_status", d, 32'h4);
      bus_read(32'h8, d);
      check("abort_steps", d, 32'd0);
      frozen = gray(p0 + 1);
      for (int k = 0; k < 8; k++) begin
        check("frozen", {30'd0, enc_a, enc_b}, {30'd0, frozen});
        @(negedge clk);
      end
      m_pidx = (p0 + 1) & 3;
      m_pos  = m_pos + 1;
      bus_read(32'h10, d);
      check("abort_pos", d, 32'(m_pos));
    end

    // CLR_POS, then one reverse edge wraps to all-ones
    bus_write(32'h0, 32'h7);
    m_pos = 0;
    bus_read(32'h10, d);
    check("clr_pos", d, 32'd0);
    burst(1'b0, 3, 1);
    bus_read(32'h10, d);
    check("wrap", d, 32'hFFFFFFFF);

    // Reset in the middle of a burst
    bus_write(32'h0, 32'h3);
    bus_write(32'h4, 32'd2);
    bus_write(32'h8, 32'd50);
    repeat (7) @(negedge clk);
    do_reset();
    check("rst_ab", {30'd0, enc_a, enc_b}, 32'd0);
    bus_read(32'hC, d);
    check("rst_status", d, 32'd0);
    bus_read(32'h10, d);
    check("rst_pos", d, 32'd0);
    bus_read(32'h4, d);
    check("rst_period", d, 32'd4);
    bus_read(32'h0, d);
    check("rst_ctrl", d, 32'd0);

    for (int r = 0; r < 25; r++)
      burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), int'($urandom_range(1, 12)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
